io_bank_cfg_n: RTL and testbench

//  Parametrised west/east-edge IO bank for the eFPGA fabric, successor to the fixed 2-channel IO tile.

---
 rtl/io_bank_pkg.sv | 16 +
 rtl/io_bank_chan.sv | 69 ++++++
 rtl/io_bank_cfg_n.sv | 67 ++++++
 tb/tb_io_bank_cfg_n.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// Shared field layout and input-mode encoding for the parametrised eFPGA edge IO bank.
package io_bank_pkg;
    localparam int CFG_BITS_PER_CH = 8;
    localparam int IN_MODE_LSB     = 0;
    localparam int OUT_REG_BIT     = 2;
    localparam int EN_BIT          = 3;
    localparam int CBIT_LSB        = 4;
    localparam int CBIT_W          = 4;

    typedef enum logic [1:0] {
        IM_DIRECT = 2'd0,
        IM_REG    = 2'd1,
        IM_SYNC   = 2'd2,
        IM_PULSE  = 2'd3
    } in_mode_e;
endpackage

// File: rtl/io_bank_chan.sv
// One pad channel: input capture/sync/pulse path, optional output+tristate registers, enable gating.
// Latency 0..3 cycles depending on in_mode; no backpressure, flops clock every cycle.
module io_bank_chan
    import io_bank_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CFG_BITS_PER_CH-1:0] cfg,
    input  logic                       fab_i,
    input  logic                       fab_t,
    input  logic                       o_top,
    output logic                       fab_o,
    output logic                       fab_q,
    output logic                       i_top,
    output logic                       t_top,
    output logic [CBIT_W-1:0]          c_bit
);
    in_mode_e mode;
    logic     en;
    logic     out_reg;
    logic     sync1;
    logic     sync2;
    logic     hist;
    logic     pulse;
    logic     out_r;
    logic     t_r;
    logic     mode_o;

    assign mode    = in_mode_e'(cfg[IN_MODE_LSB +: 2]);
    assign en      = cfg[EN_BIT];
    assign out_reg = cfg[OUT_REG_BIT];

    // sync1 doubles as the always-on fab_Q capture flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
            pulse <= 1'b0;
            out_r <= 1'b0;
            t_r   <= 1'b1;
        end else begin
            sync1 <= o_top;
            sync2 <= sync1;
            hist  <= sync2;
            pulse <= sync2 & ~hist;
            out_r <= fab_i;
            t_r   <= fab_t;
        end
    end

    always_comb begin
        mode_o = 1'b0;
        case (mode)
            IM_DIRECT: mode_o = o_top;
            IM_REG:    mode_o = sync1;
            IM_SYNC:   mode_o = sync2;
            IM_PULSE:  mode_o = pulse;
            default:   mode_o = 1'b0;
        endcase
    end

    // Tristate shares the data path's registration so I and T stay cycle-aligned.
    assign fab_o = en & mode_o;
    assign fab_q = en & sync1;
    assign i_top = en & (out_reg ? out_r : fab_i);
    assign t_top = ~en | (out_reg ? t_r : fab_t);
    assign c_bit = cfg[CBIT_LSB +: CBIT_W];
endmodule

// File: rtl/io_bank_cfg_n.sv
// NUM_CH-channel edge IO bank: frame-written config register file plus per-channel datapaths.
// Config takes effect from the capturing edge; frame/clock signals pass through combinationally.
module io_bank_cfg_n
    import io_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FRAME_BITS = 32,
    parameter int MAX_FRAMES = 20
) (
    input  logic                    UserCLK,
    input  logic                    Reset,
    output logic                    UserCLKo,
    input  logic [FRAME_BITS-1:0]   FrameData,
    output logic [FRAME_BITS-1:0]   FrameData_O,
    input  logic [MAX_FRAMES-1:0]   FrameStrobe,
    output logic [MAX_FRAMES-1:0]   FrameStrobe_O,
    input  logic [NUM_CH-1:0]       fab_I,
    input  logic [NUM_CH-1:0]       fab_T,
    output logic [NUM_CH-1:0]       fab_O,
    output logic [NUM_CH-1:0]       fab_Q,
    input  logic [NUM_CH-1:0]       O_top,
    output logic [NUM_CH-1:0]       I_top,
    output logic [NUM_CH-1:0]       T_top,
    output logic [NUM_CH*CBIT_W-1:0] C_bit
);
    localparam int CFG_W = NUM_CH * CFG_BITS_PER_CH;

    if (NUM_CH < 1 || NUM_CH > 16 || CFG_W > FRAME_BITS * MAX_FRAMES) begin : g_bad_params
        $error("io_bank_cfg_n: NUM_CH must be 1..16 and NUM_CH*8 must fit in FRAME_BITS*MAX_FRAMES");
    end

    logic [CFG_W-1:0] cfg;
    logic [CFG_W-1:0] cfg_nxt;

    assign UserCLKo      = UserCLK;
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;

    // Bit k lives in frame k/FRAME_BITS at row position k%FRAME_BITS; all strobed frames load together.
    for (genvar k = 0; k < CFG_W; k++) begin : g_cfg_bit
        assign cfg_nxt[k] = FrameStrobe[k / FRAME_BITS] ? FrameData[k % FRAME_BITS] : cfg[k];
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            cfg <= '0;
        end else begin
            cfg <= cfg_nxt;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        io_bank_chan u_chan (
            .clk   (UserCLK),
            .rst   (Reset),
            .cfg   (cfg[c*CFG_BITS_PER_CH +: CFG_BITS_PER_CH]),
            .fab_i (fab_I[c]),
            .fab_t (fab_T[c]),
            .o_top (O_top[c]),
            .fab_o (fab_O[c]),
            .fab_q (fab_Q[c]),
            .i_top (I_top[c]),
            .t_top (T_top[c]),
            .c_bit (C_bit[c*CBIT_W +: CBIT_W])
        );
    end
endmodule

// File: tb/tb_io_bank_cfg_n.sv
// Scoreboard bench for io_bank_cfg_n at NUM_CH=16: expectations queued at stimulus, checked after the DUT responds.
module tb_io_bank_cfg_n;
    localparam int NCH = 16;
    localparam int FB  = 32;
    localparam int MF  = 20;

    logic            UserCLK = 1'b0;
    logic            Reset;
    logic            UserCLKo;
    logic [FB-1:0]   FrameData;
    logic [FB-1:0]   FrameData_O;
    logic [MF-1:0]   FrameStrobe;
    logic [MF-1:0]   FrameStrobe_O;
    logic [NCH-1:0]  fab_I, fab_T, fab_O, fab_Q, O_top, I_top, T_top;
    logic [NCH*4-1:0] C_bit;

    io_bank_cfg_n #(.NUM_CH(NCH), .FRAME_BITS(FB), .MAX_FRAMES(MF)) dut (
        .UserCLK(UserCLK), .Reset(Reset), .UserCLKo(UserCLKo),
        .FrameData(FrameData), .FrameData_O(FrameData_O),
        .FrameStrobe(FrameStrobe), .FrameStrobe_O(FrameStrobe_O),
        .fab_I(fab_I), .fab_T(fab_T), .fab_O(fab_O), .fab_Q(fab_Q),
        .O_top(O_top), .I_top(I_top), .T_top(T_top), .C_bit(C_bit)
    );

    always #5 UserCLK = ~UserCLK;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic         mon_on  = 1'b0;
    logic [127:0] sb_q[$];
    logic [127:0] exp_v;
    logic [127:0] cfg_exp;

    task automatic tick();
        @(posedge UserCLK);
        #2;
    endtask

    task automatic idle_inputs();
        FrameStrobe = '0;
        fab_I       = '0;
        fab_T       = '1;
        O_top       = '0;
    endtask

    always @(negedge UserCLK) begin
        if (mon_on) begin
            n_tests++;
            if (FrameData_O !== FrameData || FrameStrobe_O !== FrameStrobe || UserCLKo !== UserCLK) begin
                n_fail++;
                $display("FAIL passthrough: got data %h strobe %h clk %b, want %h %h %b",
                         FrameData_O, FrameStrobe_O, UserCLKo, FrameData, FrameStrobe, UserCLK);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        FrameData = $urandom;
        sb_q.push_back({16'hffff, 48'h0, 64'h0});
        tick();
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({T_top, I_top, fab_O, fab_Q, C_bit} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", {T_top, I_top, fab_O, fab_Q, C_bit}, exp_v);
        end
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fab_I = NCH'($urandom); fab_T = NCH'($urandom); O_top = NCH'($urandom);
            FrameData = $urandom;
            sb_q.push_back({16'hffff, 48'h0, 64'h0});
            #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({T_top, I_top, fab_O, fab_Q, C_bit} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, {T_top, I_top, fab_O, fab_Q, C_bit}, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_frame_write();
        idle_inputs();
        FrameData = 32'h0000_00F8;
        FrameStrobe = 20'h1;
        fab_I[0] = 1'b1;
        fab_T[0] = 1'b0;
        sb_q.push_back(128'({16'h0000, 16'hffff, 64'h0}));
        sb_q.push_back(128'({16'h0001, 16'hfffe, 64'hF}));
        #1;
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({I_top, T_top, C_bit} !== exp_v[95:0]) begin
            n_fail++;
            $display("FAIL frame_before_edge: got %h want %h", {I_top, T_top, C_bit}, exp_v[95:0]);
        end
        tick();
        FrameStrobe = '0;
        FrameData = $urandom;
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({I_top, T_top, C_bit} !== exp_v[95:0]) begin
            n_fail++;
            $display("FAIL frame_loaded: got %h want %h", {I_top, T_top, C_bit}, exp_v[95:0]);
        end
        // direct input path: {fab_O[0], fab_Q[0]}
        O_top[0] = 1'b1;
        sb_q.push_back(128'(2'b10)); sb_q.push_back(128'(2'b11));
        sb_q.push_back(128'(2'b01)); sb_q.push_back(128'(2'b00));
        for (int i = 0; i < 4; i++) begin
            if (i == 1 || i == 3) tick();
            if (i == 2) O_top[0] = 1'b0;
            #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({fab_O[0], fab_Q[0]} !== exp_v[1:0]) begin
                n_fail++;
                $display("FAIL direct_in[%0d]: got %b want %b", i, {fab_O[0], fab_Q[0]}, exp_v[1:0]);
            end
        end
        // registered output and tristate: {I_top[0], T_top[0]}
        FrameData = 32'h0000_00FC;
        FrameStrobe = 20'h1;
        tick();
        FrameStrobe = '0;
        fab_I[0] = 1'b0;
        fab_T[0] = 1'b1;
        sb_q.push_back(128'(2'b10)); sb_q.push_back(128'(2'b01));
        sb_q.push_back(128'(2'b01)); sb_q.push_back(128'(2'b10));
        for (int i = 0; i < 4; i++) begin
            if (i == 1 || i == 3) tick();
            if (i == 2) begin fab_I[0] = 1'b1; fab_T[0] = 1'b0; end
            #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({I_top[0], T_top[0]} !== exp_v[1:0]) begin
                n_fail++;
                $display("FAIL reg_out[%0d]: got %b want %b", i, {I_top[0], T_top[0]}, exp_v[1:0]);
            end
        end
    endtask

    task automatic test_sync();
        idle_inputs();
        FrameData = 32'h090B_0AF8;
        FrameStrobe = 20'h1;
        tick();
        FrameStrobe = '0;
        tick(); tick();
        // {fab_O[1], fab_Q[1], fab_O[3]}: rise, then fall after three edges
        O_top[1] = 1'b1;
        O_top[3] = 1'b1;
        sb_q.push_back(128'(3'b000)); sb_q.push_back(128'(3'b011));
        sb_q.push_back(128'(3'b111)); sb_q.push_back(128'(3'b111));
        sb_q.push_back(128'(3'b100)); sb_q.push_back(128'(3'b000));
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (i == 3) begin O_top[1] = 1'b0; O_top[3] = 1'b0; end
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({fab_O[1], fab_Q[1], fab_O[3]} !== exp_v[2:0]) begin
                n_fail++;
                $display("FAIL sync_reg[%0d]: got %b want %b", i, {fab_O[1], fab_Q[1], fab_O[3]}, exp_v[2:0]);
            end
        end
    endtask

    task automatic test_pulse();
        int pulses;
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        for (int rep = 0; rep < 2; rep++) begin
            pulses = 0;
            O_top[2] = 1'b1;
            for (int k = 1; k <= 8; k++) sb_q.push_back(128'(k == 3));
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k == 5) O_top[2] = 1'b0;
                exp_v = sb_q.pop_front();
                if (fab_O[2] === 1'b1) pulses++;
                n_tests++;
                if (fab_O[2] !== exp_v[0]) begin
                    n_fail++;
                    $display("FAIL pulse[%0d][%0d]: got %b want %b", rep, k, fab_O[2], exp_v[0]);
                end
            end
            n_tests++;
            if (pulses != 1) begin
                n_fail++;
                $display("FAIL pulse_count[%0d]: got %0d want 1", rep, pulses);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        Reset = 1'b1;
        FrameData = 32'hFFFF_FFFF;
        FrameStrobe = 20'h1;
        sb_q.push_back(128'({64'h0, 16'hffff}));
        tick();
        Reset = 1'b0;
        FrameStrobe = '0;
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({C_bit, T_top} !== exp_v[79:0]) begin
            n_fail++;
            $display("FAIL reset_beats_strobe: got %h want %h", {C_bit, T_top}, exp_v[79:0]);
        end
        FrameData = 32'h0000_0AF8;
        FrameStrobe = 20'h1;
        sb_q.push_back(128'(64'hF));
        tick();
        FrameStrobe = '0;
        exp_v = sb_q.pop_front();
        n_tests++;
        if (C_bit !== exp_v[63:0]) begin
            n_fail++;
            $display("FAIL strobe_after_reset: got %h want %h", C_bit, exp_v[63:0]);
        end
        O_top[1] = 1'b1;
        fab_I = 16'hA5A5;
        sb_q.push_back(128'(1'b1));
        tick(); tick();
        exp_v = sb_q.pop_front();
        n_tests++;
        if (fab_O[1] !== exp_v[0]) begin
            n_fail++;
            $display("FAIL sync_before_reset: got %b want %b", fab_O[1], exp_v[0]);
        end
        Reset = 1'b1;
        sb_q.push_back({16'hffff, 48'h0, 64'h0});
        tick();
        exp_v = sb_q.pop_front();
        n_tests++;
        if ({T_top, I_top, fab_O, fab_Q, C_bit} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want %h", {T_top, I_top, fab_O, fab_Q, C_bit}, exp_v);
        end
        Reset = 1'b0;
        FrameData = 32'h0000_0A00;
        FrameStrobe = 20'h1;
        sb_q.push_back(128'(1'b0));
        sb_q.push_back(128'(1'b1));
        for (int i = 0; i < 2; i++) begin
            tick();
            FrameStrobe = '0;
            exp_v = sb_q.pop_front();
            n_tests++;
            if (fab_O[1] !== exp_v[0]) begin
                n_fail++;
                $display("FAIL sync_flushed[%0d]: got %b want %b", i, fab_O[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_all_channels();
        logic [15:0] et, ei, eo;
        logic [63:0] ec;
        idle_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int c = 0; c < NCH; c++)
            cfg_exp[c*8 +: 8] = {4'(c), (c % 2 == 0), 3'b000};
        for (int f = 0; f < 4; f++) begin
            FrameData = cfg_exp[f*32 +: 32];
            FrameStrobe = '0;
            FrameStrobe[f] = 1'b1;
            tick();
        end
        FrameStrobe = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                // frames 0 and 1 together, plus an unmapped frame that must be ignored
                FrameData = 32'h0808_0808;
                FrameStrobe = 20'h00403;
                cfg_exp[63:0] = {8{8'h08}};
                tick();
                FrameStrobe = '0;
            end
            fab_I = NCH'($urandom); fab_T = NCH'($urandom); O_top = NCH'($urandom);
            FrameData = $urandom;
            for (int c = 0; c < NCH; c++) begin
                ec[c*4 +: 4] = cfg_exp[c*8+4 +: 4];
                et[c] = cfg_exp[c*8+3] ? fab_T[c] : 1'b1;
                ei[c] = cfg_exp[c*8+3] ? fab_I[c] : 1'b0;
                eo[c] = cfg_exp[c*8+3] ? O_top[c] : 1'b0;
            end
            sb_q.push_back(128'({et, ei, eo, ec}));
            #1;
            exp_v = sb_q.pop_front();
            n_tests++;
            if ({T_top, I_top, fab_O, C_bit} !== exp_v[111:0]) begin
                n_fail++;
                $display("FAIL all_channels[%0d]: got %h want %h", i, {T_top, I_top, fab_O, C_bit}, exp_v[111:0]);
            end
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1;
        FrameData = '0;
        idle_inputs();
        mon_on = 1'b1;
        test_reset();
        test_frame_write();
        test_sync();
        test_pulse();
        test_reset_mid();
        test_all_channels();
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
